password_index_decoder: RTL
===========================

Name: password_index_decoder

Overview:
- Converts a 4-character ASCII password into its base-36 candidate index. Alphabet order: '0'-'9' = 0-9, 'A'-'Z' = 10-35.
- This is the inverse of the cracker's index-to-candidate enumeration. The host uses it to predict the hit index and to check which cracker partition owns a password.
- Partitions are defined by a first-digit window [from, to]. The block also reports whether the password's first digit falls inside that window.
- Sequential: one character per clock, valid/ready handshake on both sides.

Parameters:
- NUM_CHARS, 4, password length in characters.
- CHAR_W, 8, bits per ASCII character.
- DIGIT_W, 6, bits per base-36 digit; also the width of from/to.
- IDX_W, 21, index width; must satisfy 36^NUM_CHARS - 1 < 2^IDX_W.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  password/from/to are valid.
- in_ready  out  1  block can accept a new password.
- password  in  NUM_CHARS*CHAR_W  ASCII string; most significant character in the top byte.
- from  in  DIGIT_W  inclusive lower first-digit bound.
- to  in  DIGIT_W  inclusive upper first-digit bound.
- out_valid  out  1  result is valid.
- out_ready  in  1  consumer accepts the result.
- index  out  IDX_W  base-36 value of the password.
- first_digit  out  DIGIT_W  digit of the most significant character.
- in_range  out  1  from <= first_digit <= to, and err = 0.
- err  out  1  at least one character is outside the alphabet.

Behaviour:
- Reset (rst = 1 at an edge, from any state):
  - state = IDLE.
  - in_ready = 1.
  - out_valid, index, first_digit, in_range, err = 0.
- States: IDLE, CONV, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch password, from and to; clear the accumulator and err; char counter = NUM_CHARS-1; go to CONV.
- CONV:
  - in_ready = 0.
  - Each edge decodes the character at the counter: acc <= acc*36 + digit.
  - On the first character, capture first_digit.
  - An invalid character contributes digit 0 and sets sticky err.
  - After the counter-0 character, go to DONE and register index, first_digit, err and in_range.
  - Exactly NUM_CHARS edges in CONV.
- DONE:
  - out_valid = 1; outputs held stable until out_valid && out_ready.
  - On the handshake edge go to IDLE. out_valid drops and in_ready rises in the next cycle; no back-to-back acceptance.
- Latency: out_valid first high NUM_CHARS cycles after the accept edge. Throughput: one password per NUM_CHARS+2 cycles with out_ready held high.
- Arithmetic: the accumulator is IDX_W bits and cannot overflow for legal parameters. Multiply by 36 is implemented as (acc<<5)+(acc<<2).
- Boundary cases:
  - from > to: in_range = 0.
  - err = 1 forces in_range = 0; index still reflects the zero-substituted digits.
  - in_valid while not in IDLE: ignored, inputs not latched.
  - Changes to password/from/to after acceptance: no effect.
  - out_ready while not in DONE: ignored.
  - Reset during CONV or DONE: result discarded, state returns to IDLE as in reset.

Optional Feature:
- Macro: PID_LOWERCASE_EN.
- Defined: 'a'-'z' decode to 10-35, same as uppercase.
- Undefined: lowercase characters are invalid and set err.

Decomposition:
- Shared package pc_pkg holds:
  - RADIX = 36.
  - ASCII bound constants ('0', '9', 'A', 'Z', 'a', 'z').
  - Default NUM_CHARS, DIGIT_W, IDX_W.
  - Decoder state enum (IDLE/CONV/DONE).
- One sub-module: pc_char_decode. Combinational: CHAR_W char in, DIGIT_W digit plus valid out. It honours PID_LOWERCASE_EN and is shared with the cracker's checker logic.

Test Plan:
- "0001", from 0, to 35, out_ready = 1:
  - index = 1, first_digit = 0, in_range = 1, err = 0.
  - out_valid exactly 4 cycles after accept.
- "ZZZZ", from 35, to 35:
  - index = 1679615, first_digit = 35, in_range = 1.
- "A000", from 0, to 9:
  - index = 466560, first_digit = 10, in_range = 0.
  - Repeat with from 12, to 3: in_range = 0.
- "00#1":
  - err = 1, index = 1, in_range = 0.
  - "a001" with PID_LOWERCASE_EN defined: index = 466561, err = 0.
  - "a001" without PID_LOWERCASE_EN: err = 1.
- Backpressure: out_ready low for 3 cycles in DONE:
  - out_valid and outputs stable; in_ready = 0.
  - in_valid with a new password during this window is ignored.
  - Handshake, then in_ready = 1 on the next cycle.
- Assert rst during the 2nd CONV cycle:
  - Next cycle: in_ready = 1, out_valid = 0, all outputs 0.
  - Following "0010" decodes to 36.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared constants and types for the password cracker blocks: radix,
// ASCII alphabet bounds, default widths and the index decoder state enum.
package pc_pkg;

  localparam int RADIX         = 36;
  localparam int NUM_CHARS_DEF = 4;
  localparam int CHAR_W_DEF    = 8;
  localparam int DIGIT_W_DEF   = 6;
  localparam int IDX_W_DEF     = 21;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_9  = 8'h39;
  localparam logic [7:0] ASCII_UA = 8'h41;
  localparam logic [7:0] ASCII_UZ = 8'h5A;
  localparam logic [7:0] ASCII_LA = 8'h61;
  localparam logic [7:0] ASCII_LZ = 8'h7A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } pid_state_e;

endpackage

// File: rtl/pc_char_decode.sv
// Combinational ASCII-to-base-36 digit decoder. Lowercase letters decode
// like uppercase only when PID_LOWERCASE_EN is defined.
module pc_char_decode
  import pc_pkg::*;
#(
  parameter int CHAR_W  = CHAR_W_DEF,
  parameter int DIGIT_W = DIGIT_W_DEF
) (
  input  logic [CHAR_W-1:0]  char_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               valid_o
);

  logic [CHAR_W-1:0] off;

  always_comb begin
    off     = '0;
    digit_o = '0;
    valid_o = 1'b0;
    if (char_i >= CHAR_W'(ASCII_0) && char_i <= CHAR_W'(ASCII_9)) begin
      off     = char_i - CHAR_W'(ASCII_0);
      digit_o = off[DIGIT_W-1:0];
      valid_o = 1'b1;
    end else if (char_i >= CHAR_W'(ASCII_UA) && char_i <= CHAR_W'(ASCII_UZ)) begin
      off     = char_i - CHAR_W'(ASCII_UA) + CHAR_W'(10);
      digit_o = off[DIGIT_W-1:0];
      valid_o = 1'b1;
    end
`ifdef PID_LOWERCASE_EN
    else if (char_i >= CHAR_W'(ASCII_LA) && char_i <= CHAR_W'(ASCII_LZ)) begin
      off     = char_i - CHAR_W'(ASCII_LA) + CHAR_W'(10);
      digit_o = off[DIGIT_W-1:0];
      valid_o = 1'b1;
    end
`endif
  end

endmodule

// File: rtl/password_index_decoder.sv
// Sequential password-to-index decoder: one character per clock, MSB first,
// plus first-digit partition check. Lowercase support via PID_LOWERCASE_EN.
module password_index_decoder
  import pc_pkg::*;
#(
  parameter int NUM_CHARS = NUM_CHARS_DEF,
  parameter int CHAR_W    = CHAR_W_DEF,
  parameter int DIGIT_W   = DIGIT_W_DEF,
  parameter int IDX_W     = IDX_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_CHARS*CHAR_W-1:0] password,
  input  logic [DIGIT_W-1:0]          from,
  input  logic [DIGIT_W-1:0]          to,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [IDX_W-1:0]            index,
  output logic [DIGIT_W-1:0]          first_digit,
  output logic                        in_range,
  output logic                        err,
  output logic [1:0]                  dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE, out_valid only in DONE; the DONE outputs
  // stay stable until the output transfer.

  localparam int CNT_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

  pid_state_e                  state_q, state_d;
  logic [NUM_CHARS*CHAR_W-1:0] pwd_q, pwd_d;
  logic [DIGIT_W-1:0]          from_q, from_d, to_q, to_d;
  logic [IDX_W-1:0]            acc_q, acc_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic                        err_acc_q, err_acc_d;
  logic [DIGIT_W-1:0]          fd_q, fd_d;
  logic [IDX_W-1:0]            index_q, index_d;
  logic [DIGIT_W-1:0]          first_digit_q, first_digit_d;
  logic                        in_range_q, in_range_d;
  logic                        err_q, err_d;

  logic [CHAR_W-1:0]  cur_char;
  logic [DIGIT_W-1:0] cur_digit;
  logic               cur_valid;
  logic [DIGIT_W-1:0] fd_now;
  logic               err_now;
  logic [IDX_W-1:0]   acc_next;

  assign cur_char = pwd_q[CHAR_W*int'(cnt_q) +: CHAR_W];

  pc_char_decode #(
    .CHAR_W  (CHAR_W),
    .DIGIT_W (DIGIT_W)
  ) u_char_decode (
    .char_i  (cur_char),
    .digit_o (cur_digit),
    .valid_o (cur_valid)
  );

  // Invalid characters already decode to digit 0, so only err needs care.
  assign err_now  = err_acc_q | ~cur_valid;
  assign fd_now   = (cnt_q == CNT_W'(NUM_CHARS-1)) ? cur_digit : fd_q;
  assign acc_next = (acc_q << 5) + (acc_q << 2) + IDX_W'(cur_digit);

  always_comb begin
    state_d       = state_q;
    pwd_d         = pwd_q;
    from_d        = from_q;
    to_d          = to_q;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    err_acc_d     = err_acc_q;
    fd_d          = fd_q;
    index_d       = index_q;
    first_digit_d = first_digit_q;
    in_range_d    = in_range_q;
    err_d         = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pwd_d     = password;
          from_d    = from;
          to_d      = to;
          acc_d     = '0;
          err_acc_d = 1'b0;
          cnt_d     = CNT_W'(NUM_CHARS-1);
          state_d   = CONV;
        end
      end
      CONV: begin
        acc_d     = acc_next;
        err_acc_d = err_now;
        fd_d      = fd_now;
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d       = DONE;
          index_d       = acc_next;
          first_digit_d = fd_now;
          err_d         = err_now;
          in_range_d    = ~err_now && (from_q <= fd_now) && (fd_now <= to_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      pwd_q         <= '0;
      from_q        <= '0;
      to_q          <= '0;
      acc_q         <= '0;
      cnt_q         <= '0;
      err_acc_q     <= 1'b0;
      fd_q          <= '0;
      index_q       <= '0;
      first_digit_q <= '0;
      in_range_q    <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pwd_q         <= pwd_d;
      from_q        <= from_d;
      to_q          <= to_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      err_acc_q     <= err_acc_d;
      fd_q          <= fd_d;
      index_q       <= index_d;
      first_digit_q <= first_digit_d;
      in_range_q    <= in_range_d;
      err_q         <= err_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign index       = index_q;
  assign first_digit = first_digit_q;
  assign in_range    = in_range_q;
  assign err         = err_q;
  assign dbg_state_o = state_q;

endmodule
